// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: FSM state encoding and the
// default widths used by the ALU, control and accumulator blocks.
package nn_pkg;

    localparam int NN_NBITS    = 32;
    localparam int NN_MAXTERMS = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } nn_state_t;

endpackage

// File: rtl/nn_term_counter.sv
// Down-counter holding the number of product terms still to be accumulated.
module nn_term_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates bias plus a fixed number of product terms for one neuron and
// presents the sum, its activation sign and a sticky overflow flag.
module neuron_accumulator
    import nn_pkg::*;
#(
    parameter int NBITS    = NN_NBITS,
    parameter int MAXTERMS = NN_MAXTERMS,
    parameter int CW       = $clog2(MAXTERMS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    num_terms,
    input  logic [NBITS-1:0] bias,
    input  logic             in_valid,
    input  logic [NBITS-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_sum,
    output logic             out_fire,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAXTERMS);

    nn_state_t        r_state;
    logic [NBITS-1:0] r_acc;
    logic             r_ovf;

    logic [CW-1:0]    w_num_clamped;
    logic [CW-1:0]    w_count;
    logic             w_zero;
    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic [NBITS-1:0] w_sum;
    logic             w_add_ovf;

    assign w_num_clamped = (num_terms > MAX_CNT) ? MAX_CNT : num_terms;
    assign w_load        = (r_state == S_IDLE) && start;
    // The zero guard only matters if ACCUM were ever entered with no terms left.
    assign w_xfer        = (r_state == S_ACCUM) && in_valid && !w_zero;
    assign w_last        = w_xfer && (w_count == CW'(1));
    assign w_sum         = r_acc + in_data;
    assign w_add_ovf     = (r_acc[NBITS-1] == in_data[NBITS-1]) &&
                           (w_sum[NBITS-1] != r_acc[NBITS-1]);

    nn_term_counter #(
        .CW(CW)
    ) u_term_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_num_clamped),
        .dec      (w_xfer),
        .count    (w_count),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= bias;
                        r_ovf   <= 1'b0;
                        r_state <= (w_num_clamped == '0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc <= w_sum;
                        if (w_add_ovf) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_sum   = r_acc;
    assign out_fire  = ~r_acc[NBITS-1];
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: inputs change and outputs are
// checked on the falling edge, away from the active rising edge.
module tb_neuron_accumulator;

    localparam int NBITS = 32;
    localparam int CW    = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CW-1:0]    num_terms;
    logic [NBITS-1:0] bias;
    logic             in_valid;
    logic [NBITS-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_sum;
    logic             out_fire;
    logic             out_ovf;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    neuron_accumulator #(
        .NBITS    (32),
        .MAXTERMS (16),
        .CW       (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_terms (num_terms),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_fire  (out_fire),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [NBITS-1:0] obs,
                       input logic [NBITS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic rdy, input logic vld,
                             input logic bsy);
        chk({tag, "/in_ready"},  32'(in_ready),  32'(rdy));
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(vld));
        chk({tag, "/busy"},      32'(busy),      32'(bsy));
    endtask

    task automatic chk_result(input string tag, input logic [NBITS-1:0] sum,
                              input logic fire, input logic ovf);
        chk({tag, "/out_sum"},  out_sum,         sum);
        chk({tag, "/out_fire"}, 32'(out_fire),   32'(fire));
        chk({tag, "/out_ovf"},  32'(out_ovf),    32'(ovf));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_terms = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Reset state
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk_result("reset", 32'h0, 1'b1, 1'b0);

        // Scenario 1: bias 5, terms 10, -4, 7 back-to-back -> 18
        start = 1'b1; num_terms = 5'd3; bias = 32'd5;
        tick();
        start = 1'b0;
        chk_flags("s1_accum", 1'b1, 1'b0, 1'b1);
        chk("s1_acc_bias", out_sum, 32'd5);
        in_valid = 1'b1; in_data = 32'd10;
        tick();
        in_data = -32'd4;
        tick();
        in_data = 32'd7;
        chk("s1_acc_2", out_sum, 32'd11);
        chk("s1_not_done", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk_flags("s1_done", 1'b0, 1'b1, 1'b1);
        chk_result("s1", 32'd18, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_flags("s1_idle", 1'b0, 1'b0, 1'b0);

        // Scenario 2: bias 0, terms -3, 1 with 2-cycle gaps -> -2
        start = 1'b1; num_terms = 5'd2; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = -32'd3;
        tick();
        in_valid = 1'b0; in_data = 32'h5555_5555;
        chk("s2_gap1_rdy", 32'(in_ready), 32'd1);
        chk("s2_gap1_acc", out_sum, 32'hFFFF_FFFD);
        tick();
        chk("s2_gap2_rdy", 32'(in_ready), 32'd1);
        chk("s2_gap2_acc", out_sum, 32'hFFFF_FFFD);
        tick();
        chk("s2_gap3_acc", out_sum, 32'hFFFF_FFFD);
        in_valid = 1'b1; in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        chk_flags("s2_done", 1'b0, 1'b1, 1'b1);
        chk_result("s2", 32'hFFFF_FFFE, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Scenario 3: signed overflow 0x7FFFFFFF + 1
        start = 1'b1; num_terms = 5'd1; bias = 32'h7FFF_FFFF;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        chk_flags("s3_done", 1'b0, 1'b1, 1'b1);
        chk_result("s3", 32'h8000_0000, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Scenario 4: zero terms goes straight to DONE
        start = 1'b1; num_terms = 5'd0; bias = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        chk_flags("s4_done", 1'b0, 1'b1, 1'b1);
        chk_result("s4", 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Scenario 5: hold DONE for 4 cycles with start pulsed
        for (int i = 0; i < 4; i++) begin
            start = (i == 1); num_terms = 5'd2; bias = 32'd123;
            tick();
            chk($sformatf("s5_hold%0d_vld", i), 32'(out_valid), 32'd1);
            chk($sformatf("s5_hold%0d_sum", i), out_sum, 32'hFFFF_FFFF);
            chk($sformatf("s5_hold%0d_ovf", i), 32'(out_ovf), 32'd0);
        end
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk_flags("s5_idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk_flags("s5_still_idle", 1'b0, 1'b0, 1'b0);

        // Scenario 6: reset after 1 of 3 terms aborts the neuron
        start = 1'b1; num_terms = 5'd3; bias = 32'd100;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1;
        tick();
        chk("s6_acc_1", out_sum, 32'd101);
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk_flags("s6_reset", 1'b0, 1'b0, 1'b0);
        chk_result("s6_reset", 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s6_no_vld%0d", i), 32'(out_valid), 32'd0);
        end
        start = 1'b1; num_terms = 5'd2; bias = 32'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd2;
        tick();
        in_data = 32'd3;
        tick();
        in_valid = 1'b0;
        chk_flags("s6_done", 1'b0, 1'b1, 1'b1);
        chk_result("s6", 32'd6, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset takes priority over start in the same cycle
        start = 1'b1; num_terms = 5'd1; bias = 32'd9; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        chk_flags("rst_vs_start", 1'b0, 1'b0, 1'b0);
        chk("rst_vs_start_sum", out_sum, 32'h0);

        // num_terms above MAXTERMS clamps to 16 terms
        start = 1'b1; num_terms = 5'd31; bias = 32'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd1;
        for (int i = 0; i < 15; i++) tick();
        chk("clamp_15_vld", 32'(out_valid), 32'd0);
        chk("clamp_15_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_flags("clamp_done", 1'b0, 1'b1, 1'b1);
        chk_result("clamp", 32'd16, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_flags("clamp_idle", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 Parameter NBITS, default 32, data width; matches the ALU result width.
REQ-002 Parameter MAXTERMS, default 16, maximum products per neuron.
REQ-003 Parameter CW, default 5, term-count width, equal to $clog2(MAXTERMS)+1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a new neuron; sampled in IDLE only.
REQ-007 num_terms  input  CW  number of products to accumulate (0..MAXTERMS); sampled with start.
REQ-008 bias  input  NBITS  initial accumulator value; sampled with start.
REQ-009 in_valid  input  1  in_data holds a product from the ALU multiply operation.
REQ-010 in_data  input  NBITS  product term, two's complement.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 out_valid  output  1  out_sum, out_fire and out_ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_sum  output  NBITS  bias plus all accepted terms, modulo 2^NBITS.
REQ-015 out_fire  output  1  1 when signed out_sum >= 0 (non-negative activation).
REQ-016 out_ovf  output  1  sticky signed-overflow flag for the current neuron.
REQ-017 busy  output  1  1 in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ACCUM, DONE.
REQ-019 IDLE, start=1, num_terms>0: load acc=bias, remaining=num_terms, ovf=0; next state ACCUM.
REQ-020 IDLE, start=1, num_terms=0: load acc=bias, ovf=0; next state DONE, with no input transfers.
REQ-021 start is ignored in ACCUM and DONE; num_terms>MAXTERMS is clamped to MAXTERMS.
REQ-022 in_ready = 1 only in ACCUM; a transfer occurs when in_valid && in_ready.
REQ-023 Each transfer: acc <= acc + in_data (NBITS wrap); remaining decrements by 1.
REQ-024 ovf is set on any transfer where both operands have equal sign bits and the sum's sign bit differs; it stays set until the next start.
REQ-025 On the transfer that makes remaining 0, next state is DONE; out_valid is 1 the cycle after the last transfer (1-cycle latency).
REQ-026 ACCUM with in_valid=0: stall; hold acc and remaining.
REQ-027 out_valid = 1 only in DONE; out_sum, out_fire and out_ovf are stable while out_valid && !out_ready.
REQ-028 DONE with out_ready=1: next state IDLE; start asserted in that same cycle is ignored.
REQ-029 out_sum, out_fire and out_ovf are driven from registered acc/ovf in all states; their values are don't-care outside DONE.
REQ-030 out_fire uses signed comparison: out_fire = ~acc[NBITS-1].

Reset
REQ-031 reset=1 at a clock edge forces state IDLE, acc=0, remaining=0, ovf=0.
REQ-032 After reset: in_ready=0, out_valid=0, busy=0, out_sum=0, out_fire=1, out_ovf=0.
REQ-033 Reset mid-ACCUM or mid-DONE aborts the neuron; no result is produced; reset takes priority over start and transfers in the same cycle.

Structure
REQ-034 Shared package nn_pkg holds the FSM state enumeration and the NBITS/MAXTERMS defaults, shared with the ALU and control blocks.
REQ-035 Sub-module nn_term_counter (load, decrement, zero flag, width CW) holds remaining; the FSM and adder stay in the top module.
REQ-036 The output stage is not combinationally dependent on in_valid or out_ready.

Verification
REQ-037 Bench covers the following directed scenarios:
- bias=5, num_terms=3, terms 10,-4,7 back-to-back -> out_valid 1 cycle after the 3rd transfer; out_sum=18, out_fire=1, out_ovf=0.
- bias=0, num_terms=2, terms -3,1 with in_valid gaps of 2 cycles -> in_ready held 1, acc unchanged in gaps; out_sum=-2 (0xFFFFFFFE), out_fire=0.
- bias=0x7FFFFFFF, num_terms=1, term 1 -> out_sum=0x80000000, out_ovf=1, out_fire=0.
- num_terms=0, bias=-1 -> DONE next cycle, no in_ready pulse; out_sum=0xFFFFFFFF, out_fire=0.
- DONE with out_ready low for 4 cycles, and start pulsed there -> outputs stable, start ignored; out_ready=1 -> IDLE next cycle.
- reset asserted after 1 of 3 terms -> IDLE next cycle, out_valid never rises; a new start then produces the correct sum.
